// File: rtl/regfile_wport_arb_if.sv
// regfile_wport_arb_if: write-port arbitration bundle between WB stage, long-latency unit, decode query and register file
// master: drives wb_*, lu_valid/lu_waddr/lu_wdata, q_addr; receives lu_ready, rf_*, stall_req, q_hit/q_data
// slave : the arbiter side of the same signals
interface regfile_wport_arb_if #(parameter int AW = 5, parameter int DW = 32);
  logic          wb_we;
  logic [AW-1:0] wb_waddr;
  logic [DW-1:0] wb_wdata;
  logic          lu_valid;
  logic          lu_ready;
  logic [AW-1:0] lu_waddr;
  logic [DW-1:0] lu_wdata;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          stall_req;
  logic [AW-1:0] q_addr;
  logic          q_hit;
  logic [DW-1:0] q_data;
  modport master(output wb_we, wb_waddr, wb_wdata, lu_valid, lu_waddr, lu_wdata, q_addr,
                 input lu_ready, rf_we, rf_waddr, rf_wdata, stall_req, q_hit, q_data);
  modport slave(input wb_we, wb_waddr, wb_wdata, lu_valid, lu_waddr, lu_wdata, q_addr,
                output lu_ready, rf_we, rf_waddr, rf_wdata, stall_req, q_hit, q_data);
endinterface

// File: rtl/regfile_wport_arb.sv
// regfile_wport_arb: shares the register file write port between WB (priority) and a queued long-latency unit
// clk: clock; rst: synchronous active-low reset
// bus.wb_*: writeback request; bus.lu_*: long-latency result handshake
// bus.rf_*: registered register file write; bus.stall_req: registered drain request
// bus.q_addr/q_hit/q_data: combinational forwarding query over live queued entries
module regfile_wport_arb #(
  parameter int AW = 5,
  parameter int DW = 32,
  parameter int DEPTH = 4,
  parameter int MAX_WAIT = 8
) (
  input logic clk,
  input logic rst,
  regfile_wport_arb_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [AW-1:0] faddr [DEPTH];
  logic [DW-1:0] fdata [DEPTH];
  logic [DEPTH-1:0] live;
  logic [PW-1:0] head, tail, idx;
  logic [PW:0] count;
  logic [CW-1:0] wcnt;
  logic wb_issue, pop, push, head_live, qh;
  logic [DW-1:0] qd;
  assign wb_issue = bus.wb_we && bus.wb_waddr != '0;
  assign pop = !wb_issue && count != '0;
  // live bits are cleared on pop, so a live bit always marks an occupied slot
  assign head_live = live[head];
  assign bus.lu_ready = count < (PW + 1)'(DEPTH);
  // zero-address results and results already overwritten by this cycle's WB are consumed silently
  assign push = bus.lu_valid && bus.lu_ready && bus.lu_waddr != '0 &&
                !(wb_issue && bus.lu_waddr == bus.wb_waddr);
  always_ff @(posedge clk) begin
    if (push) begin
      faddr[tail] <= bus.lu_waddr;
      fdata[tail] <= bus.lu_wdata;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      live <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      wcnt <= '0;
      bus.stall_req <= 1'b0;
      bus.rf_we <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (wb_issue && faddr[i] == bus.wb_waddr) live[i] <= 1'b0;
      if (pop) begin
        live[head] <= 1'b0;
        head <= head + PW'(1);
      end
      if (push) begin
        live[tail] <= 1'b1;
        tail <= tail + PW'(1);
      end
      count <= count + (PW + 1)'(push) - (PW + 1)'(pop);
      bus.rf_we <= wb_issue || (pop && head_live);
      bus.rf_waddr <= wb_issue ? bus.wb_waddr : faddr[head];
      bus.rf_wdata <= wb_issue ? bus.wb_wdata : fdata[head];
      // a dead head that is blocked neither ages nor resets the counter
      wcnt <= (pop || count == '0) ? '0 :
              (head_live && wcnt != CW'(MAX_WAIT)) ? wcnt + CW'(1) : wcnt;
      bus.stall_req <= pop ? 1'b0 : (bus.stall_req || wcnt == CW'(MAX_WAIT));
    end
  end
  // scan from oldest to youngest so the youngest live match wins
  always_comb begin
    qh = 1'b0;
    qd = '0;
    idx = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (bus.q_addr != '0 && live[idx] && faddr[idx] == bus.q_addr) begin
        qh = 1'b1;
        qd = fdata[idx];
      end
    end
  end
  assign bus.q_hit = qh;
  assign bus.q_data = qd;
endmodule

// File: doc/regfile_wport_arb.md
Name: regfile_wport_arb

Overview:
- Arbiter that shares the general register file's single write port between two sources: the in-order pipeline writeback stage and a long-latency result unit (divider/multi-cycle ops).
- Writeback always has priority. Long-latency results queue in a small FIFO and drain into idle write slots.
- Adds starvation stall, write-after-write supersede, and a forwarding query port so the decode stage can see results that are queued but not yet written.
- Sits between the WB stage / long-latency unit and the register file write inputs.

Parameters:
AW, 5, register address width
DW, 32, data width
DEPTH, 4, long-latency FIFO entries (power of 2, >=2)
MAX_WAIT, 8, consecutive blocked cycles before stall request (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (rst==0 resets on rising clk)
wb_we  in  1  pipeline writeback valid
wb_waddr  in  AW  pipeline writeback address
wb_wdata  in  DW  pipeline writeback data
lu_valid  in  1  long-latency result valid
lu_ready  out  1  FIFO can accept
lu_waddr  in  AW  long-latency result address
lu_wdata  in  DW  long-latency result data
rf_we  out  1  register file write enable (registered)
rf_waddr  out  AW  register file write address (registered)
rf_wdata  out  DW  register file write data (registered)
stall_req  out  1  request pipeline freeze to drain FIFO (registered)
q_addr  in  AW  forwarding query address
q_hit  out  1  query matches a live queued entry
q_data  out  DW  data of youngest matching live entry

Behaviour:
- Reset (rst==0 at posedge): rf_we=0, rf_waddr=0, rf_wdata=0, stall_req=0, FIFO emptied, all entry live bits cleared, wait counter=0. Reset mid-operation discards queued results without writing them.
- Write slot selection, evaluated each cycle; the chosen write appears on rf_* the next cycle (1-cycle latency):
  - wb_we=1 and wb_waddr!=0: WB write issued.
  - Otherwise, FIFO non-empty: pop the head. If the head is live, issue its write. If it is dead, rf_we=0 that cycle.
  - Otherwise: rf_we=0.
- wb_we=1 with wb_waddr=0: no write is issued, and the slot is treated as idle, so the FIFO may pop.
- Handshake: lu_ready = (count < DEPTH), computed from current count only. A full FIFO is not ready even in a cycle it pops. Transfer occurs when lu_valid && lu_ready.
- Accepted entry with lu_waddr=0: consumed, not enqueued.
- Supersede (WAW): when a WB write to address A (A!=0) is issued, every queued entry with address A has its live bit cleared. An entry accepted in the same cycle with lu_waddr==A is consumed and not enqueued. WB is the younger producer and always wins.
- Simultaneous push and pop: both occur; count is unchanged.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Starvation:
  - wait counter increments each cycle the FIFO head is live and not popped. It clears on any pop or when the FIFO is empty.
  - stall_req is set the cycle after the counter reaches MAX_WAIT, and clears the cycle after a pop.
  - The pipeline holds wb_we=0 while stall_req=1. If wb_we=1 anyway, WB still wins.
- Query port (combinational):
  - q_hit=1 iff q_addr!=0 and some live queued entry has address q_addr. q_data is that entry's data; the youngest wins. q_data=0 when there is no hit.
  - Entries enqueued this cycle and rf_* outputs are not visible to the query. The register file's own write bypass covers rf_*.

Test Plan:
- Reset then idle: rf_we=0, lu_ready=1, stall_req=0. Then WB write r3=0x1234 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0x1234.
- Push lu results r5=0xAAAA and r6=0xBBBB with wb_we=0 -> rf writes r5, then r6, on consecutive cycles after a 1-cycle latency. Meanwhile q_addr=6 -> q_hit=1, q_data=0xBBBB until r6 is popped.
- Fill 4 entries while WB writes every cycle -> lu_ready=0 at count 4; stall_req=1 eight cycles after the head became blocked. Drop wb_we -> 4 drains, stall_req clears after the first pop, lu_ready returns to 1.
- Queue r7=0x1; then WB writes r7=0x2 -> queued r7 dies and q_hit(7)=0. Only r7=0x2 reaches rf; the dead entry's pop produces rf_we=0.
- Same-cycle lu r9=0x11 and WB r9=0x22 -> only 0x22 is written, and the FIFO count is unchanged. Also: lu entry with waddr 0 -> accepted, never written.
- Assert rst=0 with 3 entries queued -> next cycle count=0, rf_we=0, stall_req=0, q_hit=0. No queued write ever appears after reset.
